// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle layout,
// the per-edge update action and a saturating counter helper.
package id_ex_stage_pkg;

  // Packed decoder control bundle, MSB first:
  // Mem_Mode[2:0] MemRead MemWrite RegWrite MemToReg Br_Mask[7:0] ALUop[1:0] LUI AUIPC Imme
  localparam int unsigned CTRL_WIDTH       = 20;

  localparam int unsigned CTRL_MEM_MODE_HI = 19;
  localparam int unsigned CTRL_MEM_MODE_LO = 17;
  localparam int unsigned CTRL_MEMREAD     = 16;
  localparam int unsigned CTRL_MEMWRITE    = 15;
  localparam int unsigned CTRL_REGWRITE    = 14;
  localparam int unsigned CTRL_MEMTOREG    = 13;
  localparam int unsigned CTRL_BR_MASK_HI  = 12;
  localparam int unsigned CTRL_BR_MASK_LO  = 5;
  localparam int unsigned CTRL_ALUOP_HI    = 4;
  localparam int unsigned CTRL_ALUOP_LO    = 3;
  localparam int unsigned CTRL_LUI         = 2;
  localparam int unsigned CTRL_AUIPC       = 1;
  localparam int unsigned CTRL_IMME        = 0;

  // Br_Mask[7] marks an instruction that does not read rs1 as a register
  // (JAL); Br_Mask[5:0] are the conditional branches that compare rs1/rs2.
  localparam int unsigned CTRL_BR_JAL      = CTRL_BR_MASK_HI;
  localparam int unsigned CTRL_BR_CMP_HI   = CTRL_BR_MASK_LO + 5;

  localparam logic [CTRL_WIDTH-1:0] CTRL_NOP = '0;

  localparam int unsigned BUBBLE_CNT_W = 32;

  // What the ID/EX register does on the next rising edge.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } ex_action_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    return (v == '1) ? v : v + BUBBLE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection between the ID instruction and the
// load currently sitting in EX.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_lui,
  input  logic       i_id_auipc,
  input  logic       i_id_br_jal,
  input  logic [5:0] i_id_br_cmp,
  input  logic       i_id_memwrite,
  input  logic       i_id_imme,
  input  logic       i_flush,
  input  logic       i_hold,
  output logic       o_load_use,
  output logic       o_stall
);

  logic rs1_used;
  logic rs2_used;
  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  // Decode operand usage of the ID instruction and compare against the EX load.
  always_comb begin
    rs1_used   = ~(i_id_lui | i_id_auipc | i_id_br_jal);
    rs2_used   = i_id_memwrite | (|i_id_br_cmp) | ~i_id_imme;
    ex_is_load = i_ex_valid & i_ex_memread & (i_ex_rd != 5'd0);
    rs1_match  = rs1_used & (i_id_rs1 == i_ex_rd);
    rs2_match  = rs2_used & (i_id_rs2 == i_ex_rd);
    o_load_use = ex_is_load & i_id_valid & (rs1_match | rs2_match);
    o_stall    = o_load_use & ~i_flush & ~i_hold;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold, load-use bubble insertion and a
// saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = CTRL_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic [XLEN-1:0]         i_pc,
  input  logic [XLEN-1:0]         i_rs1_data,
  input  logic [XLEN-1:0]         i_rs2_data,
  input  logic [XLEN-1:0]         i_imm,
  input  logic [4:0]              i_rs1,
  input  logic [4:0]              i_rs2,
  input  logic [4:0]              i_rd,
  input  logic [2:0]              i_funct3,
  input  logic                    i_funct7b5,
  input  logic [CTRL_W-1:0]       i_ctrl,
  input  logic                    i_flush,
  input  logic                    i_hold,
  output logic                    o_valid,
  output logic [XLEN-1:0]         o_pc,
  output logic [XLEN-1:0]         o_rs1_data,
  output logic [XLEN-1:0]         o_rs2_data,
  output logic [XLEN-1:0]         o_imm,
  output logic [4:0]              o_rs1,
  output logic [4:0]              o_rs2,
  output logic [4:0]              o_rd,
  output logic [2:0]              o_funct3,
  output logic                    o_funct7b5,
  output logic [CTRL_W-1:0]       o_ctrl,
  output logic                    o_stall,
  output logic [BUBBLE_CNT_W-1:0] o_bubble_cnt
);

  logic                    valid_q,    valid_d;
  logic [XLEN-1:0]         pc_q,       pc_d;
  logic [XLEN-1:0]         rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]         rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]         imm_q,      imm_d;
  logic [4:0]              rs1_q,      rs1_d;
  logic [4:0]              rs2_q,      rs2_d;
  logic [4:0]              rd_q,       rd_d;
  logic [2:0]              funct3_q,   funct3_d;
  logic                    funct7b5_q, funct7b5_d;
  logic [CTRL_W-1:0]       ctrl_q,     ctrl_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic       load_use;
  ex_action_e action;

  hazard_detect u_hazard_detect (
    .i_ex_valid    (valid_q),
    .i_ex_memread  (ctrl_q[CTRL_MEMREAD]),
    .i_ex_rd       (rd_q),
    .i_id_valid    (i_valid),
    .i_id_rs1      (i_rs1),
    .i_id_rs2      (i_rs2),
    .i_id_lui      (i_ctrl[CTRL_LUI]),
    .i_id_auipc    (i_ctrl[CTRL_AUIPC]),
    .i_id_br_jal   (i_ctrl[CTRL_BR_JAL]),
    .i_id_br_cmp   (i_ctrl[CTRL_BR_CMP_HI:CTRL_BR_MASK_LO]),
    .i_id_memwrite (i_ctrl[CTRL_MEMWRITE]),
    .i_id_imme     (i_ctrl[CTRL_IMME]),
    .i_flush       (i_flush),
    .i_hold        (i_hold),
    .o_load_use    (load_use),
    .o_stall       (o_stall)
  );

  // Resolve the per-edge action: flush beats hold beats load-use beats load.
  always_comb begin
    action = ACT_LOAD;
    if (i_flush) begin
      action = ACT_FLUSH;
    end else if (i_hold) begin
      action = ACT_HOLD;
    end else if (load_use) begin
      action = ACT_BUBBLE;
    end
  end

  // Next-state values for the pipeline register and bubble counter.
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    funct7b5_d   = funct7b5_q;
    ctrl_d       = ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    unique case (action)
      ACT_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_W'(CTRL_NOP);
      end
      ACT_HOLD: begin
      end
      ACT_BUBBLE: begin
        valid_d      = 1'b0;
        ctrl_d       = CTRL_W'(CTRL_NOP);
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end
      ACT_LOAD: begin
        valid_d    = i_valid;
        pc_d       = i_pc;
        rs1_data_d = i_rs1_data;
        rs2_data_d = i_rs2_data;
        imm_d      = i_imm;
        rs1_d      = i_rs1;
        rs2_d      = i_rs2;
        rd_d       = i_rd;
        funct3_d   = i_funct3;
        funct7b5_d = i_funct7b5;
        ctrl_d     = i_valid ? i_ctrl : CTRL_W'(CTRL_NOP);
      end
      default: begin
      end
    endcase
  end

  // Pipeline register and counter, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      funct7b5_q   <= 1'b0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      funct7b5_q   <= funct7b5_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_pc         = pc_q;
  assign o_rs1_data   = rs1_data_q;
  assign o_rs2_data   = rs2_data_q;
  assign o_imm        = imm_q;
  assign o_rs1        = rs1_q;
  assign o_rs2        = rs2_q;
  assign o_rd         = rd_q;
  assign o_funct3     = funct3_q;
  assign o_funct7b5   = funct7b5_q;
  assign o_ctrl       = ctrl_q;
  assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a behavioural model of the EX-stage register contents.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int CW   = 20;
  localparam int DW   = 4*XLEN + 15 + 3 + 1;
  localparam int KW   = 1 + CW + 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_valid;
  logic [XLEN-1:0] i_pc, i_rs1_data, i_rs2_data, i_imm;
  logic [4:0]      i_rs1, i_rs2, i_rd;
  logic [2:0]      i_funct3;
  logic            i_funct7b5;
  logic [CW-1:0]   i_ctrl;
  logic            i_flush, i_hold;
  logic            o_valid;
  logic [XLEN-1:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]      o_rs1, o_rs2, o_rd;
  logic [2:0]      o_funct3;
  logic            o_funct7b5;
  logic [CW-1:0]   o_ctrl;
  logic            o_stall;
  logic [31:0]     o_bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model of what EX should hold.
  logic          m_valid;
  logic [CW-1:0] m_ctrl;
  logic [31:0]   m_cnt;
  logic [DW-1:0] m_data;
  bit            m_known;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_pc(i_pc),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_ctrl(i_ctrl), .i_flush(i_flush), .i_hold(i_hold),
    .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_funct3(o_funct3),
    .o_funct7b5(o_funct7b5), .o_ctrl(o_ctrl), .o_stall(o_stall),
    .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Control word in decoder field order.
  function automatic logic [CW-1:0] mk(input logic [2:0] mode, input logic mr, input logic mw,
                                       input logic rw, input logic m2r, input logic [7:0] br,
                                       input logic [1:0] aop, input logic lui, input logic auipc,
                                       input logic imme);
    return {mode, mr, mw, rw, m2r, br, aop, lui, auipc, imme};
  endfunction

  logic [CW-1:0] C_LW, C_ADD, C_LUI, C_SW, C_BEQ, C_JAL;

  function automatic logic [KW-1:0] dut_ctl();
    return {o_valid, o_ctrl, o_bubble_cnt};
  endfunction
  function automatic logic [KW-1:0] exp_ctl();
    return {m_valid, m_ctrl, m_cnt};
  endfunction
  function automatic logic [DW-1:0] dut_data();
    return {o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd, o_funct3, o_funct7b5};
  endfunction

  // Load-use as a rule: a valid non-x0 load in EX whose rd the ID instruction reads.
  function automatic bit model_lu();
    bit reads1, reads2, ex_load;
    reads1  = !(i_ctrl[2] || i_ctrl[1] || i_ctrl[12]);
    reads2  = i_ctrl[15] || (i_ctrl[10:5] != 6'd0) || !i_ctrl[0];
    ex_load = m_valid && m_ctrl[16] && (m_data[8:4] != 5'd0);
    return ex_load && i_valid && ((reads1 && i_rs1 == m_data[8:4]) || (reads2 && i_rs2 == m_data[8:4]));
  endfunction
  function automatic logic model_stall();
    return logic'(model_lu() && !i_flush && !i_hold);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_cnt = '0; m_data = '0; m_known = 1'b1;
  endtask

  task automatic model_edge();
    bit lu;
    lu = model_lu();
    if (i_flush) begin
      m_valid = 1'b0; m_ctrl = '0; m_known = 1'b0;
    end else if (i_hold) begin
      m_valid = m_valid;
    end else if (lu) begin
      m_valid = 1'b0; m_ctrl = '0; m_known = 1'b0;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end else begin
      m_valid = i_valid;
      m_ctrl  = i_valid ? i_ctrl : '0;
      m_data  = {i_pc, i_rs1_data, i_rs2_data, i_imm, i_rs1, i_rs2, i_rd, i_funct3, i_funct7b5};
      m_known = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic fl, input logic ho);
    i_valid = v; i_ctrl = c; i_rs1 = r1; i_rs2 = r2; i_rd = rd; i_flush = fl; i_hold = ho;
    i_pc = $urandom; i_rs1_data = $urandom; i_rs2_data = $urandom; i_imm = $urandom;
    i_funct3 = 3'($urandom); i_funct7b5 = 1'($urandom);
  endtask

  task automatic test_reset();
    #3;
    model_reset();
    checks++; if (dut_ctl() !== exp_ctl()) begin errors++; $display("FAIL reset_ctl: got %h want %h", dut_ctl(), exp_ctl()); end
    checks++; if (dut_data() !== m_data) begin errors++; $display("FAIL reset_data: got %h want %h", dut_data(), m_data); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", o_stall); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_first_load();
    drive(1'b1, C_ADD, 5'd3, 5'd4, 5'd7, 1'b0, 1'b0);
    tick();
    checks++; if (dut_ctl() !== exp_ctl()) begin errors++; $display("FAIL first_load_ctl: got %h want %h", dut_ctl(), exp_ctl()); end
    checks++; if (dut_data() !== m_data) begin errors++; $display("FAIL first_load_data: got %h want %h", dut_data(), m_data); end
    checks++; if (o_valid !== 1'b1 || o_rd !== 5'd7) begin errors++; $display("FAIL first_load_rd: got v=%b rd=%0d want v=1 rd=7", o_valid, o_rd); end
  endtask

  task automatic test_invalid_load();
    drive(1'b0, C_LW, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
    tick();
    checks++; if (o_valid !== 1'b0 || o_ctrl !== '0) begin errors++; $display("FAIL invalid_ctrl: got v=%b ctrl=%h want v=0 ctrl=0", o_valid, o_ctrl); end
    checks++; if (dut_data() !== m_data) begin errors++; $display("FAIL invalid_data: got %h want %h", dut_data(), m_data); end
  endtask

  task automatic test_load_use();
    logic [31:0] cnt0;
    drive(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 1'b0, 1'b0);
    tick();
    cnt0 = m_cnt;
    drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", o_stall); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_ctrl !== '0 || o_bubble_cnt !== cnt0 + 32'd1) begin
      errors++; $display("FAIL lu_bubble: got v=%b ctrl=%h cnt=%h want v=0 ctrl=0 cnt=%h", o_valid, o_ctrl, o_bubble_cnt, cnt0 + 32'd1); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_one_cycle: got %b want 0", o_stall); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_rd !== 5'd6 || dut_ctl() !== exp_ctl()) begin
      errors++; $display("FAIL lu_add_enters: got %h want %h", dut_ctl(), exp_ctl()); end
  endtask

  task automatic test_x0();
    logic [31:0] cnt0;
    drive(1'b1, C_LW, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    cnt0 = m_cnt;
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", o_stall); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_bubble_cnt !== cnt0) begin errors++; $display("FAIL x0_nobubble: got v=%b cnt=%h want v=1 cnt=%h", o_valid, o_bubble_cnt, cnt0); end
  endtask

  task automatic test_operand_use();
    drive(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, C_LUI, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lui_stall: got %b want 0", o_stall); end
    drive(1'b1, C_SW, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL sw_stall: got %b want 1", o_stall); end
    tick();
    checks++; if (dut_ctl() !== exp_ctl()) begin errors++; $display("FAIL sw_bubble: got %h want %h", dut_ctl(), exp_ctl()); end
  endtask

  task automatic test_flush();
    logic [31:0] cnt0;
    drive(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 1'b0, 1'b0);
    tick();
    cnt0 = m_cnt;
    drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", o_stall); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_ctrl !== '0 || o_bubble_cnt !== cnt0) begin
      errors++; $display("FAIL flush_state: got v=%b ctrl=%h cnt=%h want v=0 ctrl=0 cnt=%h", o_valid, o_ctrl, o_bubble_cnt, cnt0); end
  endtask

  task automatic test_hold_and_saturate();
    logic [KW-1:0] k0;
    logic [DW-1:0] d0;
    drive(1'b1, C_LW, 5'd3, 5'd0, 5'd5, 1'b0, 1'b0);
    tick();
    k0 = dut_ctl(); d0 = dut_data();
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, C_ADD, 5'd5, 5'($urandom), 5'($urandom), 1'b0, 1'b1);
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL hold_stall[%0d]: got %b want 0", n, o_stall); end
      tick();
      checks++; if (dut_ctl() !== exp_ctl() || dut_ctl() !== k0 || dut_data() !== d0) begin
        errors++; $display("FAIL hold_frozen[%0d]: got %h/%h want %h/%h", n, dut_ctl(), dut_data(), exp_ctl(), m_data); end
    end
    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
      tick();
      checks++; if (o_bubble_cnt !== 32'hFFFF_FFFF || dut_ctl() !== exp_ctl()) begin
        errors++; $display("FAIL saturate[%0d]: got %h want %h", n, o_bubble_cnt, 32'hFFFF_FFFF); end
      drive(1'b1, C_LW, 5'd3, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b want 1", o_stall); end
    i_rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (dut_ctl() !== exp_ctl() || dut_data() !== m_data || o_stall !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h/%h stall=%b want all zero", dut_ctl(), dut_data(), o_stall); end
    #1;
    i_rst_n = 1'b1;
    tick();
    checks++; if (dut_ctl() !== exp_ctl() || dut_data() !== m_data || o_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_load: got %h/%h want %h/%h", dut_ctl(), dut_data(), exp_ctl(), m_data); end
  endtask

  task automatic test_random();
    logic [CW-1:0] c;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0, 1:    c = C_LW;
        2:       c = C_ADD;
        3:       c = C_LUI;
        4:       c = C_SW;
        5:       c = C_BEQ;
        default: c = ($urandom_range(0, 1) == 0) ? C_JAL : CW'($urandom);
      endcase
      drive(logic'($urandom_range(0, 9) != 0), c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 9) == 0));
      #1;
      checks++; if (o_stall !== model_stall()) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, o_stall, model_stall()); end
      tick();
      checks++; if (dut_ctl() !== exp_ctl()) begin errors++; $display("FAIL rnd_ctl[%0d]: got %h want %h", n, dut_ctl(), exp_ctl()); end
      if (m_known) begin
        checks++; if (dut_data() !== m_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, dut_data(), m_data); end
      end
    end
  endtask

  initial begin
    C_LW  = mk(3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    C_ADD = mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 1'b0);
    C_LUI = mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1);
    C_SW  = mk(3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    C_BEQ = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 2'b01, 1'b0, 1'b0, 1'b1);
    C_JAL = mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 2'b00, 1'b0, 1'b0, 1'b1);
    i_rst_n = 1'b0;
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    model_reset();
    test_reset();
    test_first_load();
    test_invalid_load();
    test_load_use();
    test_x0();
    test_operand_use();
    test_flush();
    test_hold_and_saturate();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter CTRL_W, default 20, width of the packed control bundle; layout is defined in def.v.
REQ-003 i_clk  input  1  sole clock, rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  ID-stage instruction valid.
REQ-006 i_pc / i_rs1_data / i_rs2_data / i_imm  input  XLEN each  ID-stage PC, register-file read data and sign-extended immediate.
REQ-007 i_rs1 / i_rs2 / i_rd  input  5 each  source and destination register indices.
REQ-008 i_funct3  input  3, and i_funct7b5  input  1  ALU function qualifiers.
REQ-009 i_ctrl  input  CTRL_W  packed decoder outputs: Mem_Mode[2:0], MemRead, MemWrite, RegWrite, MemToReg, Br_Mask[7:0], ALUop[1:0], LUI, AUIPC, Imme.
REQ-010 i_flush  input  1  EX-stage redirect (taken branch, JAL or JALR) that kills the ID instruction.
REQ-011 i_hold  input  1  downstream memory wait; freezes this register.
REQ-012 o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd, o_funct3, o_funct7b5, o_ctrl  output  widths as inputs  registered EX-stage copies.
REQ-013 o_stall  output  1  combinational load-use stall to the PC and IF/ID registers.
REQ-014 o_bubble_cnt  output  32  count of load-use bubbles inserted.

Function
REQ-015 The block SHALL derive rs1 usage as NOT(LUI OR AUIPC OR Br_Mask[7]).
REQ-016 The block SHALL derive rs2 usage as MemWrite OR (Br_Mask[5:0] != 0) OR NOT Imme.
REQ-017 Load-use SHALL be asserted when all of these hold: o_valid, o_ctrl.MemRead, o_rd != 0, i_valid, and (rs1 used AND i_rs1 == o_rd) OR (rs2 used AND i_rs2 == o_rd).
REQ-018 o_stall SHALL equal load-use AND NOT i_flush AND NOT i_hold.
REQ-019 Per-edge priority SHALL be reset > flush > hold > load-use > normal load.
REQ-020 On flush, the next state SHALL be o_valid=0 and o_ctrl=0; data fields are don't-care.
REQ-021 On hold, every register SHALL retain its value.
REQ-022 On load-use, the block SHALL insert a bubble (o_valid=0, o_ctrl=0) and increment o_bubble_cnt.
REQ-023 On normal load, every output SHALL take its i_ counterpart; o_ctrl SHALL be forced to 0 when i_valid=0.
REQ-024 Latency SHALL be exactly one cycle from ID to EX.
REQ-025 A load-use stall SHALL last exactly one cycle, because the bubble removes the load from EX.
REQ-026 o_bubble_cnt SHALL saturate at 0xFFFFFFFF and SHALL NOT wrap.
REQ-027 Flush coinciding with load-use SHALL NOT count a bubble and SHALL NOT assert o_stall.
REQ-028 A destination of rd=x0 SHALL never trigger a stall.

Reset
REQ-029 While i_rst_n=0, all registered outputs and o_bubble_cnt SHALL be 0 (o_valid=0, o_ctrl=0), regardless of the clock.
REQ-030 Reset asserted mid-stall SHALL clear o_stall within the same cycle, since o_valid=0.
REQ-031 The first clock edge after deassertion SHALL perform a normal load.

Structure
REQ-032 def.v SHALL hold CTRL_W, the bit index of every i_ctrl field, and CTRL_NOP=0.
REQ-033 Hazard logic SHALL be a combinational sub-module named hazard_detect; the register and counter stay in id_ex_stage.

Verification
REQ-034 Scenario 1: LW x5 in EX, ADD x6,x5,x1 in ID -> o_stall=1 for 1 cycle, then o_valid=0 in EX, o_bubble_cnt 0->1, ADD enters EX on the following edge.
REQ-035 Scenario 2: LW x0 in EX, ADD x6,x0,x0 in ID -> o_stall=0, no bubble.
REQ-036 Scenario 3: LW x5 in EX, LUI x5,0x12345 in ID -> o_stall=0 (rs1 unused); SW x5,0(x2) in ID instead -> o_stall=1.
REQ-037 Scenario 4: i_flush=1 together with a load-use condition -> o_valid=0, o_ctrl=0, o_stall=0, counter unchanged.
REQ-038 Scenario 5: i_hold=1 for 3 cycles while i_ inputs change -> outputs constant; counter preset to 0xFFFFFFFF plus one bubble -> stays 0xFFFFFFFF.
REQ-039 Scenario 6: i_rst_n pulsed low between clock edges -> all outputs 0 immediately.
